// File: rtl/mdu_hilo_pkg.sv
// rtl/mdu_hilo_pkg.sv - md_op encodings, FSM state type and op-class helper for mdu_hilo
package mdu_hilo_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Multi-cycle ops only; mthi/mtlo are single-edge writes.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - E-stage multiply/divide unit with HI/LO registers and fixed-latency commit
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        req,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e        state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      tmp_hi, tmp_lo;
   logic             tmp_dz;

   logic             go, long_go;
   logic [63:0]      prod_s, prod_u;
   logic [31:0]      b_safe, quo_s, rem_s, quo_u, rem_u;

   assign go      = start & ~req;
   assign long_go = go & is_long_op(md_op);
   assign busy    = (cnt != '0) | long_go;

   // Result computed combinationally at the start edge; the counter only delays its visibility.
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};
   assign b_safe = (B == 32'd0) ? 32'd1 : B;
   assign quo_s  = $signed(A) / $signed(b_safe);
   assign rem_s  = $signed(A) % $signed(b_safe);
   assign quo_u  = A / b_safe;
   assign rem_u  = A % b_safe;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (long_go) state_next = ST_RUN;
         ST_RUN:  if (cnt == CNT_W'(1)) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         HI     <= '0;
         LO     <= '0;
         tmp_hi <= '0;
         tmp_lo <= '0;
         tmp_dz <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE) begin
            if (go) begin
               tmp_dz <= 1'b0;
               case (md_op)
                  MD_MULT: begin
                     {tmp_hi, tmp_lo} <= prod_s;
                     cnt              <= CNT_W'(MULT_CYCLES);
                  end
                  MD_MULTU: begin
                     {tmp_hi, tmp_lo} <= prod_u;
                     cnt              <= CNT_W'(MULT_CYCLES);
                  end
                  MD_DIV: begin
                     tmp_hi <= rem_s;
                     tmp_lo <= quo_s;
                     tmp_dz <= (B == 32'd0);
                     cnt    <= CNT_W'(DIV_CYCLES);
                  end
                  MD_DIVU: begin
                     tmp_hi <= rem_u;
                     tmp_lo <= quo_u;
                     tmp_dz <= (B == 32'd0);
                     cnt    <= CNT_W'(DIV_CYCLES);
                  end
                  MD_MTHI: HI <= A;
                  MD_MTLO: LO <= A;
                  default: ;
               endcase
            end
         end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && !tmp_dz) begin
               HI <= tmp_hi;
               LO <= tmp_lo;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo against a cycle-count reference model
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = MD_NONE;
   logic [31:0] A = '0, B = '0;
   logic        req = 1'b0;
   logic        busy;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   mdu_hilo #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .A(A), .B(B), .req(req), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Reference: registers plus a scheduled commit at an absolute edge number.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          pend, p_dz;
   int          edge_n, commit_edge;

   function automatic bit long_op(input logic [2:0] op);
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi = '0; m_lo = '0; pend = 0; p_dz = 0; edge_n = 0; commit_edge = 0;
      end else begin
         edge_n++;
         if (pend) begin
            if (edge_n == commit_edge) begin
               if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
               pend = 0;
            end
         end else if (start && !req) begin
            int sa, sb;
            longint ps;
            longint unsigned pu;
            sa = A; sb = B;
            p_dz = 0;
            case (md_op)
               MD_MULT:  begin ps = longint'(sa) * longint'(sb); {p_hi, p_lo} = ps; pend = 1; commit_edge = edge_n + NM; end
               MD_MULTU: begin pu = longint'({32'd0, A}) * longint'({32'd0, B}); {p_hi, p_lo} = pu; pend = 1; commit_edge = edge_n + NM; end
               MD_DIV: begin
                  p_dz = (sb == 0);
                  if (!p_dz) begin p_lo = sa / sb; p_hi = sa % sb; end
                  pend = 1; commit_edge = edge_n + ND;
               end
               MD_DIVU: begin
                  p_dz = (B == 0);
                  if (!p_dz) begin p_lo = A / B; p_hi = A % B; end
                  pend = 1; commit_edge = edge_n + ND;
               end
               MD_MTHI: m_hi = A;
               MD_MTLO: m_lo = A;
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, pend || (start && !req && long_op(md_op))});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
      if (start && pend) check("start_while_busy", 32'd1, 32'd0);
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, output int nbusy);
      @(posedge clk); #1;
      start = 1'b1; md_op = op; A = a; B = b; req = rq;
      nbusy = 0;
      @(negedge clk);
      if (busy) nbusy++;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE; req = 1'b0; A = $urandom; B = $urandom;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         else break;
      end
      if (nbusy > 30) check("idle_timeout", 32'(nbusy), 32'd0);
   endtask

   int nb;

   initial begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, nb);
      check("t1_busy_cycles", 32'(nb), 32'd6);
      check("t1_hi", HI, 32'hFFFFFFFF);
      check("t1_lo", LO, 32'hFFFFFFFE);

      run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, nb);
      check("t2_hi", HI, 32'h00000001);
      check("t2_lo", LO, 32'hFFFFFFFE);

      run_op(MD_DIV, -32'sd7, 32'd2, 1'b0, nb);
      check("t3_busy_cycles", 32'(nb), 32'd11);
      check("t3_div_lo", LO, 32'hFFFFFFFD);
      check("t3_div_hi", HI, 32'hFFFFFFFF);
      run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, nb);
      check("t3_divu_lo", LO, 32'd3);
      check("t3_divu_hi", HI, 32'd1);

      run_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, nb);
      check("t4_mthi_busy", 32'(nb), 32'd0);
      run_op(MD_MTLO, 32'h5678, 32'd0, 1'b0, nb);
      check("t4_mtlo_busy", 32'(nb), 32'd0);
      check("t4_hi", HI, 32'h1234);
      check("t4_lo", LO, 32'h5678);

      run_op(MD_DIV, 32'd100, 32'd3, 1'b1, nb);
      check("t5_req_busy", 32'(nb), 32'd0);
      check("t5_req_hi", HI, 32'h1234);
      check("t5_req_lo", LO, 32'h5678);
      run_op(MD_DIV, 32'd100, 32'd0, 1'b0, nb);
      check("t5_dz_busy_cycles", 32'(nb), 32'd11);
      check("t5_dz_hi", HI, 32'h1234);
      check("t5_dz_lo", LO, 32'h5678);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(1, 6));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: a = 32'($urandom_range(0, 20));
            default: ;
         endcase
         if (op == MD_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         run_op(op, a, b, ($urandom_range(0, 7) == 0), nb);
      end

      run_op(MD_MTHI, 32'hA5A5A5A5, 32'd0, 1'b0, nb);
      run_op(MD_MTLO, 32'h5A5A5A5A, 32'd0, 1'b0, nb);
      @(posedge clk); #1;
      start = 1'b1; md_op = MD_DIV; A = 32'd99; B = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_hi", HI, 32'd0);
      check("t6_rst_lo", LO, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (15) @(negedge clk);
      check("t6_no_commit_hi", HI, 32'd0);
      check("t6_no_commit_lo", LO, 32'd0);
      check("t6_idle_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
